// File: rtl/stopwatch_ctrl.sv
// Run/pause/done sequencer for the 4-digit BCD stopwatch: debounces the start/stop
// button, decodes mode and preset, and drives the counter controls and done/blink status.
module stopwatch_ctrl #(
    parameter int DB_CYCLES   = 4,
    parameter int BLINK_TICKS = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        toggle,
    input  logic [1:0]  mode,
    input  logic [7:0]  sw,
    input  logic        count_zero,
    input  logic        count_max,
    output logic        load,
    output logic [15:0] load_val,
    output logic        cnt_en,
    output logic        cnt_up,
    output logic        done,
    output logic        blink
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int BW  = $clog2(BLINK_TICKS + 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        logic [3:0] res;
        if (nib > 4'd9) res = 4'd9;
        else            res = nib;
        return res;
    endfunction

    function automatic logic [15:0] preset_val(input logic [1:0] m, input logic [7:0] s);
        logic [15:0] res;
        case (m)
            2'b00:   res = 16'h0000;
            2'b01,
            2'b10:   res = {clamp_bcd(s[7:4]), clamp_bcd(s[3:0]), 8'h00};
            2'b11:   res = 16'h9999;
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

    logic           sync1_r, sync2_r;
    logic           db_level_r;
    logic [DBW-1:0] db_cnt_r;
    logic [BW-1:0]  blink_cnt_r;
    logic [1:0]     mode_r;
    state_t         state_r, state_nx_s;
    logic           press_s, term_s, mode_chg_s;
    logic           load_r, cnt_en_r, cnt_up_r, done_r, blink_r;
    logic [15:0]    load_val_r;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= toggle;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level_r <= 1'b0;
            db_cnt_r   <= '0;
        end else if (sync2_r == db_level_r) begin
            db_cnt_r   <= '0;
        end else if (db_cnt_r == DB_LAST) begin
            db_level_r <= sync2_r;
            db_cnt_r   <= '0;
        end else begin
            db_cnt_r   <= db_cnt_r + DBW'(1);
        end
    end

    // Press event, terminal condition and mode-change detection.
    always_comb begin
        press_s    = (sync2_r != db_level_r) && (db_cnt_r == DB_LAST) && sync2_r;
        mode_chg_s = (mode != mode_r);
        if (cnt_up_r) term_s = count_max;
        else          term_s = count_zero;
    end

    // Next-state logic; a mode change outside IDLE overrides everything else.
    always_comb begin
        state_nx_s = state_r;
        if (mode_chg_s && (state_r != ST_IDLE)) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (press_s) state_nx_s = ST_RUN;
                    else         state_nx_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (term_s)       state_nx_s = ST_DONE;
                    else if (press_s) state_nx_s = ST_PAUSE;
                    else              state_nx_s = ST_RUN;
                end
                ST_PAUSE: begin
                    if (press_s) state_nx_s = ST_RUN;
                    else         state_nx_s = ST_PAUSE;
                end
                ST_DONE: begin
                    if (press_s) state_nx_s = ST_IDLE;
                    else         state_nx_s = ST_DONE;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register, registered mode and registered counter controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            mode_r     <= 2'b00;
            load_r     <= 1'b0;
            load_val_r <= 16'h0000;
            cnt_en_r   <= 1'b0;
            cnt_up_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            mode_r   <= mode;
            load_r   <= (state_nx_s == ST_IDLE);
            if (state_nx_s == ST_IDLE) load_val_r <= preset_val(mode, sw);
            else                       load_val_r <= load_val_r;
            cnt_en_r <= tick && (state_r == ST_RUN) && (state_nx_s == ST_RUN);
            cnt_up_r <= ~mode[1];
            done_r   <= (state_nx_s == ST_DONE);
        end
    end

    // Blink half-period counter; restarts dark on every entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if ((state_r == ST_DONE) && (state_nx_s == ST_DONE)) begin
            if (tick) begin
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_r <= '0;
                    blink_r     <= ~blink_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BW'(1);
                end
            end
        end else begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end
    end

    assign load     = load_r;
    assign load_val = load_val_r;
    assign cnt_en   = cnt_en_r;
    assign cnt_up   = cnt_up_r;
    assign done     = done_r;
    assign blink    = blink_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the controller.
module tb_stopwatch_ctrl;

    localparam int DB    = 4;
    localparam int BLINK = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, toggle = 1'b0, count_zero = 1'b0, count_max = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  sw = 8'h00;
    logic        load, cnt_en, cnt_up, done, blink;
    logic [15:0] load_val;

    int total = 0;
    int bad = 0;
    int en_seen = 0;

    stopwatch_ctrl #(.DB_CYCLES(DB), .BLINK_TICKS(BLINK)) dut (
        .clk(clk), .reset(reset), .tick(tick), .toggle(toggle), .mode(mode), .sw(sw),
        .count_zero(count_zero), .count_max(count_max), .load(load), .load_val(load_val),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .done(done), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_IDLE, P_RUN, P_PAUSE, P_DONE} phase_e;
    phase_e      ph = P_IDLE;
    bit          tq1 = 1'b0, tq2 = 1'b0, lvl = 1'b0;
    bit          hist[$];
    int          done_ticks = 0;
    logic [1:0]  m_mode = 2'b00;
    logic        m_load = 1'b0, m_en = 1'b0, m_up = 1'b0, m_done = 1'b0, m_blink = 1'b0;
    logic [15:0] m_val = 16'h0000;

    function automatic logic [15:0] model_preset(input logic [1:0] m, input logic [7:0] s);
        int hi, lo;
        hi = (s[7:4] > 9) ? 9 : int'(s[7:4]);
        lo = (s[3:0] > 9) ? 9 : int'(s[3:0]);
        if (m == 2'b00) return 16'h0000;
        if (m == 2'b11) return 16'h9999;
        return 16'(hi * 4096 + lo * 256);
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            ph = P_IDLE; tq1 = 0; tq2 = 0; lvl = 0; hist.delete(); done_ticks = 0;
            m_mode = 2'b00; m_load = 0; m_en = 0; m_up = 0; m_done = 0; m_blink = 0;
            m_val = 16'h0000;
        end else begin
            bit samp, press, term, flip;
            phase_e nx;
            samp = tq2; tq2 = tq1; tq1 = toggle;
            hist.push_back(samp);
            if (hist.size() > DB) void'(hist.pop_front());
            press = 0;
            if (hist.size() == DB) begin
                flip = 1;
                foreach (hist[i]) if (hist[i] == lvl) flip = 0;
                if (flip) begin lvl = !lvl; press = lvl; end
            end
            term = m_up ? count_max : count_zero;
            nx = ph;
            if (mode != m_mode && ph != P_IDLE) nx = P_IDLE;
            else if (ph == P_IDLE && press) nx = P_RUN;
            else if (ph == P_RUN && term) nx = P_DONE;
            else if (ph == P_RUN && press) nx = P_PAUSE;
            else if (ph == P_PAUSE && press) nx = P_RUN;
            else if (ph == P_DONE && press) nx = P_IDLE;
            m_en = (ph == P_RUN && nx == P_RUN && tick);
            if (ph == P_DONE && nx == P_DONE) begin
                if (tick) done_ticks++;
            end else done_ticks = 0;
            m_blink = ((done_ticks / BLINK) % 2) == 1;
            m_load = (nx == P_IDLE);
            if (m_load) m_val = model_preset(mode, sw);
            m_done = (nx == P_DONE);
            m_up = !mode[1];
            m_mode = mode;
            ph = nx;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("load", {15'd0, load}, {15'd0, m_load});
        chk("load_val", load_val, m_val);
        chk("cnt_en", {15'd0, cnt_en}, {15'd0, m_en});
        chk("cnt_up", {15'd0, cnt_up}, {15'd0, m_up});
        chk("done", {15'd0, done}, {15'd0, m_done});
        chk("blink", {15'd0, blink}, {15'd0, m_blink});
        if (cnt_en === 1'b1) en_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic press_button();
        @(posedge clk); #2 toggle = 1'b1;
        repeat (8) @(posedge clk);
        #2 toggle = 1'b0;
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #2 tick = 1'b1;
        @(posedge clk); #2 tick = 1'b0;
    endtask

    initial begin
        int base;
        #3 reset = 1'b0;
        #1 chk("rst_load", {15'd0, load}, 16'd0);
        chk("rst_val", load_val, 16'h0000);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t0_load_first", {15'd0, load}, 16'd1);
        chk("t0_up", {15'd0, cnt_up}, 16'd1);

        // Glitch shorter than the debounce window is ignored.
        @(posedge clk); #2 toggle = 1'b1;
        repeat (2) @(posedge clk);
        #2 toggle = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("t3_glitch_idle", {15'd0, load}, 16'd1);
        // Bouncy press yields exactly one press: IDLE -> RUN, not back out.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2 toggle = (i % 2 == 0);
        end
        repeat (10) @(posedge clk);
        #2 toggle = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("t3_bounce_run", {15'd0, load}, 16'd0);
        press_button();   // RUN -> PAUSE

        // Up count from zero: 150 ticks -> 150 enables, then pause holds.
        press_button();
        @(negedge clk) chk("t1_val", load_val, 16'h0000);
        base = en_seen;
        for (int i = 0; i < 150; i++) begin
            pulse_tick();
            @(posedge clk); #2;
        end
        repeat (3) @(posedge clk);
        #2;
        press_button();
        for (int i = 0; i < 10; i++) pulse_tick();
        repeat (2) @(posedge clk);
        @(negedge clk) chk("t1_enables", 16'(en_seen - base), 16'd150);

        // Down from clamped preset, terminal at count_zero.
        @(posedge clk); #2 mode = 2'b10; sw = 8'h1F;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("t2_val", load_val, 16'h1900);
        press_button();
        @(negedge clk) chk("t2_down", {15'd0, cnt_up}, 16'd0);
        for (int i = 0; i < 20; i++) pulse_tick();
        @(posedge clk); #2 count_zero = 1'b1;
        @(posedge clk);
        @(negedge clk) chk("t2_done", {15'd0, done}, 16'd1);
        #2 count_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) chk("t2_no_en", {15'd0, cnt_en}, 16'd0);
        end

        // Blink toggles at tick 50 and tick 100 in DONE.
        for (int i = 1; i <= 100; i++) begin
            pulse_tick();
            @(negedge clk);
            if (i == 49) chk("t4_blink49", {15'd0, blink}, 16'd0);
            if (i == 50) chk("t4_blink50", {15'd0, blink}, 16'd1);
            if (i == 99) chk("t4_blink99", {15'd0, blink}, 16'd1);
            if (i == 100) chk("t4_blink100", {15'd0, blink}, 16'd0);
        end
        press_button();
        @(negedge clk) chk("t4_done_clr", {15'd0, done}, 16'd0);

        // Mode change mid-RUN forces IDLE with new preset; async reset.
        @(posedge clk); #2 mode = 2'b01; sw = 8'h42;
        press_button();
        for (int i = 0; i < 3; i++) pulse_tick();
        @(posedge clk); #2 mode = 2'b11;
        @(posedge clk);
        @(negedge clk) chk("t5_load", {15'd0, load}, 16'd1);
        chk("t5_val", load_val, 16'h9999);
        press_button();
        @(posedge clk); #2 reset = 1'b0;
        #1 chk("t5_rst_out", {load_val[14:0] | {14'd0, load}, cnt_en | cnt_up | done | blink},
               16'd0);
        mode = 2'b00;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk) chk("t5_rel_noload", {15'd0, load}, 16'd0);
        @(posedge clk);
        @(negedge clk) chk("t5_rel_load", {15'd0, load}, 16'd1);

        // Same-cycle press and terminal in RUN: terminal wins.
        press_button();
        @(posedge clk); #2 toggle = 1'b1;
        repeat (5) @(posedge clk);
        #2 count_max = 1'b1;
        @(posedge clk); #2 count_max = 1'b0;
        @(negedge clk) chk("t6_done", {15'd0, done}, 16'd1);
        repeat (4) @(posedge clk);
        #2 toggle = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) chk("t6_still_done", {15'd0, done}, 16'd1);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 11) == 0) toggle = ~toggle;
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0) sw = 8'($urandom);
            count_zero = ($urandom_range(0, 39) == 0);
            count_max = ($urandom_range(0, 39) == 0);
            if (c == 1500) reset = 1'b0;
            if (c == 1503) reset = 1'b1;
        end
        @(posedge clk); #2 tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
